trigger_info_packetizer: RTL
============================

Name: trigger_info_packetizer

Overview:
Downstream consumer of bram_data_serial. On each completed readout (falling edge of the serializer's busy), captures the DATA_WIDTH*REAL_DEPTH wide frame and emits it as a ready/valid word stream: one header word, then REAL_DEPTH payload words. The output feeds the trigger-info transmit path (UART/link FIFO). Frames that arrive while a packet is still draining are dropped and counted.

Parameters:
DATA_WIDTH, 8, width of one payload word and of m_data
REAL_DEPTH, 128, payload words per frame (must be >= 2)
HEADER_WORD, 8'hA5, constant first word of every packet (DATA_WIDTH bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_busy  in  1  busy from bram_data_serial; frame valid on its falling edge
src_data  in  DATA_WIDTH*REAL_DEPTH  wide frame from bram_data_serial
m_data  out  DATA_WIDTH  stream word
m_valid  out  1  stream word valid
m_last  out  1  final word of packet, qualified by m_valid
m_ready  in  1  downstream accept
pkt_busy  out  1  high from frame capture until final transfer
overrun  out  1  one-cycle pulse when a frame is dropped
drop_count  out  8  saturating count of dropped frames
pkt_count  out  16  completed packets, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n low): state IDLE; m_valid=0, m_last=0, m_data=0, pkt_busy=0, overrun=0, drop_count=0, pkt_count=0, busy_d=0, frame register cleared. Reset mid-packet abandons the packet; no partial completion is counted.
- Edge detect: busy_d <= src_busy each cycle; fall = busy_d & ~src_busy.
- States: IDLE, HEADER, PAYLOAD.
- IDLE: on fall, latch src_data into frame register, set pkt_busy and go to HEADER. m_valid=1 with m_data=HEADER_WORD in the next cycle (latency 1 clk from the cycle fall is seen).
- HEADER: hold m_data/m_valid until m_valid&m_ready. Then load word counter = REAL_DEPTH-1 and go to PAYLOAD.
- PAYLOAD: m_data = top word of frame (bits [DATA_WIDTH*REAL_DEPTH-1 -: DATA_WIDTH]). This word is the first word the serializer shifted in, so stream order equals BRAM read order. On each transfer, shift frame left by DATA_WIDTH and decrement the counter. m_last=1 when counter=0. Transfer with counter=0: m_valid=0, m_last=0, pkt_busy=0, pkt_count+1, go to IDLE.
- Back-to-back: transfers occur on every cycle m_ready is high. Packet length is REAL_DEPTH+1 beats, giving a minimum of REAL_DEPTH+1 cycles from first valid to the return to IDLE. A fall seen in the same cycle that the state returns to IDLE is dropped; a fall one cycle later is accepted.
- Stream rules: once m_valid rises, m_data/m_valid/m_last stay stable until a transfer occurs. All outputs are registered or muxed from registers only. There is no combinational path from m_ready to m_valid.
- Overrun: a fall while the state is not IDLE leaves the frame register untouched and pulses overrun for 1 clk. drop_count increments and saturates at 8'hFF.
- Counter width: $clog2(REAL_DEPTH).

Optional Feature:
Macro PACKETIZER_CHECKSUM_EN. When defined, a CHECK state follows PAYLOAD and emits one trailer word equal to the XOR of all REAL_DEPTH payload words, accumulated as the words are transferred and cleared on capture. m_last is asserted on the trailer instead of the last payload word, and packet length is REAL_DEPTH+2. When not defined, the CHECK state and accumulator do not exist and packet length is REAL_DEPTH+1.

Test Plan:
(Bench parameters: DATA_WIDTH=8, REAL_DEPTH=4.)
- Reset then idle: rst_n low 3 clk, src_busy=0 -> all outputs 0, m_valid never rises.
- Basic packet: src_data=32'h11223344, src_busy 1->0, m_ready=1 -> m_valid rises 1 clk after the fall. Stream is A5,11,22,33,44 with m_last only on 44, and pkt_count=1.
- Backpressure: same frame, m_ready toggled 1,0,0,1,... -> each word is held stable while m_ready=0, the sequence is unchanged, and m_last appears only on the 44 beat.
- Overrun: second fall during the payload of the first packet -> overrun pulses 1 clk, drop_count=1, and the first packet completes unchanged. A third fall after return to IDLE is accepted.
- Async reset mid-payload: assert rst_n after the 22 beat -> m_valid=0 immediately and pkt_count stays at its prior value. The next fall produces a full A5-first packet.
- PACKETIZER_CHECKSUM_EN defined: frame 32'h11223344 -> stream A5,11,22,33,44,44 (11^22^33^44=44) with m_last on the trailer.

Source files
------------

// File: rtl/trigger_info_packetizer.sv
// Captures a completed bram_data_serial frame and streams it as header + payload words (ready/valid).
// Optional trailer checksum word enabled by defining PACKETIZER_CHECKSUM_EN.
module trigger_info_packetizer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    REAL_DEPTH  = 128,
    parameter logic [DATA_WIDTH-1:0] HEADER_WORD = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             src_busy,
    input  logic [DATA_WIDTH*REAL_DEPTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    output logic                             m_last,
    input  logic                             m_ready,
    output logic                             pkt_busy,
    output logic                             overrun,
    output logic [7:0]                       drop_count,
    output logic [15:0]                      pkt_count
);

    localparam int FRAME_W = DATA_WIDTH * REAL_DEPTH;
    localparam int CNT_W   = $clog2(REAL_DEPTH);

`ifdef PACKETIZER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

    state_t               state_q, state_d;
    logic                 busy_q;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           drop_q, drop_d;
    logic [15:0]          pkt_q, pkt_d;
    logic                 fall, xfer;
    logic [DATA_WIDTH-1:0] top_word;
`ifdef PACKETIZER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    assign fall     = busy_q & ~src_busy;
    assign xfer     = m_valid & m_ready;
    assign top_word = frame_q[FRAME_W-1 -: DATA_WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (fall) state_d = S_HEADER;
            S_HEADER:  if (xfer) state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (xfer && cnt_q == '0) begin
`ifdef PACKETIZER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef PACKETIZER_CHECKSUM_EN
            S_CHECK:   if (xfer) state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Stream outputs are decoded from registered state only, so m_ready never reaches m_valid
    always_comb begin
        m_valid  = (state_q != S_IDLE);
        pkt_busy = (state_q != S_IDLE);
        m_data   = '0;
        case (state_q)
            S_HEADER:  m_data = HEADER_WORD;
            S_PAYLOAD: m_data = top_word;
`ifdef PACKETIZER_CHECKSUM_EN
            S_CHECK:   m_data = csum_q;
`endif
            default:   m_data = '0;
        endcase
`ifdef PACKETIZER_CHECKSUM_EN
        m_last = (state_q == S_CHECK);
`else
        m_last = (state_q == S_PAYLOAD) && (cnt_q == '0);
`endif
    end

    always_comb begin
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        overrun_d = fall && (state_q != S_IDLE);
        drop_d    = drop_q;
        pkt_d     = pkt_q;
`ifdef PACKETIZER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (state_q == S_IDLE && fall) begin
            frame_d = src_data;
`ifdef PACKETIZER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end
        if (state_q == S_HEADER && xfer) begin
            cnt_d = CNT_W'(REAL_DEPTH - 1);
        end
        if (state_q == S_PAYLOAD && xfer) begin
            frame_d = frame_q << DATA_WIDTH;
            cnt_d   = cnt_q - CNT_W'(1);
`ifdef PACKETIZER_CHECKSUM_EN
            csum_d  = csum_q ^ top_word;
`endif
        end
        if (overrun_d && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (xfer && m_last) begin
            pkt_d = pkt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            frame_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
            pkt_q     <= '0;
`ifdef PACKETIZER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            busy_q    <= src_busy;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            pkt_q     <= pkt_d;
`ifdef PACKETIZER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign overrun    = overrun_q;
    assign drop_count = drop_q;
    assign pkt_count  = pkt_q;

endmodule
